// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and master FSM state type.
// Also holds the command alignment rule used when a command is accepted.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ADDR = 2'b01,
      ST_DATA = 2'b10,
      ST_RESP = 2'b11
   } state_t;

   // Reserved size or an address not aligned to the size: rejected without bus activity.
   function automatic logic cmd_bad(input logic [1:0] size, input logic [1:0] addr_lo);
      return (size == 2'b11) ||
             (size == SZ_HALF && addr_lo[0]) ||
             (size == SZ_WORD && addr_lo != 2'b00);
   endfunction

endpackage

// File: rtl/ahb_data_align.sv
// Byte-lane steering: write-data replication onto HWDATA and read-lane
// extraction from HRDATA, right-aligned and zero-extended.
module ahb_data_align
   import ahb_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_bus,
   output logic [31:0] wdata_lanes,
   output logic [31:0] rdata_ext
);

   always_comb begin
      wdata_lanes = wdata;
      rdata_ext   = rdata_bus;
      case (size)
         SZ_BYTE: begin
            wdata_lanes = {4{wdata[7:0]}};
            rdata_ext   = {24'h0, rdata_bus[{addr_lo, 3'b000} +: 8]};
         end
         SZ_HALF: begin
            wdata_lanes = {2{wdata[15:0]}};
            rdata_ext   = {16'h0, rdata_bus[{addr_lo[1], 4'b0000} +: 16]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite master: one command in, one NONSEQ SINGLE
// transfer on the bus, one completion pulse out.
module ahb_lite_master
   import ahb_pkg::*;
#(
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [1:0]  cmd_size,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic        HMASTLOCK,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   state_t      state, nxt;
   logic        wr_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, wdata_q;
   logic [31:0] wdata_lanes, rdata_ext;
   logic        accept, bad;

   assign accept = cmd_valid && (state == ST_IDLE);
   assign bad    = cmd_bad(cmd_size, cmd_addr[1:0]);

   ahb_data_align u_align (
      .size        (size_q),
      .addr_lo     (addr_q[1:0]),
      .wdata       (wdata_q),
      .rdata_bus   (HRDATA),
      .wdata_lanes (wdata_lanes),
      .rdata_ext   (rdata_ext)
   );

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE: if (cmd_valid) nxt = bad ? ST_RESP : ST_ADDR;
         ST_ADDR: if (HREADY)    nxt = ST_DATA;
         ST_DATA: if (HREADY)    nxt = ST_RESP;
         ST_RESP:                nxt = ST_IDLE;
         default:                nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= ST_IDLE;
         wr_q      <= 1'b0;
         size_q    <= 2'b00;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         state <= nxt;
         if (accept) begin
            wr_q    <= cmd_write;
            size_q  <= cmd_size;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            if (bad) begin
               rsp_rdata <= 32'h0;
               rsp_err   <= 1'b1;
            end
         end
         // HRESP with HREADY low is only the first error cycle; wait for HREADY.
         if (state == ST_DATA && HREADY) begin
            rsp_rdata <= (wr_q || HRESP) ? 32'h0 : rdata_ext;
            rsp_err   <= HRESP;
         end
      end
   end

   assign cmd_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);
   assign HTRANS    = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HADDR     = addr_q;
   assign HWRITE    = wr_q;
   assign HSIZE     = {1'b0, size_q};
   assign HBURST    = HBURST_SINGLE;
   assign HPROT     = HPROT_VAL;
   assign HMASTLOCK = 1'b0;
   assign HWDATA    = (state == ST_DATA && wr_q) ? wdata_lanes : 32'h0;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Randomized bench for ahb_lite_master: the driver plays command source and
// AHB slave, a scoreboard queue feeds a monitor that checks each rsp_valid.
module tb_ahb_lite_master;
   import ahb_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [1:0]  cmd_size;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic        HWRITE, HMASTLOCK, HREADY, HRESP;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;

   always #5 HCLK = ~HCLK;

   ahb_lite_master #(.HPROT_VAL(4'b0011)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
      .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model in plain arithmetic terms.
   function automatic bit ref_bad(input logic [1:0] sz, input logic [31:0] a);
      int align;
      if (sz == 2'b11) return 1'b1;
      align = 1 << sz;
      return (a % align) != 0;
   endfunction

   function automatic logic [31:0] ref_read(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] bus);
      int nbytes;
      nbytes = 1 << sz;
      if (nbytes == 4) return bus;
      return (bus >> (8 * (a % 4))) & ((32'h1 << (8 * nbytes)) - 32'h1);
   endfunction

   function automatic logic [31:0] ref_wlanes(input logic [1:0] sz, input logic [31:0] w);
      if (sz == 2'b00) return (w & 32'hFF) * 32'h0101_0101;
      if (sz == 2'b01) return (w & 32'hFFFF) * 32'h0001_0001;
      return w;
   endfunction

   // Monitor: every completion must match the oldest outstanding expectation.
   always @(negedge HCLK) begin
      if (HRESETn === 1'b1 && rsp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response");
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, ":rsp_rdata"}, rsp_rdata, e.rdata);
            chk({e.tag, ":rsp_err"}, 32'(rsp_err), 32'(e.err));
         end
      end
   end

   // Called on a negedge with the DUT idle; returns on a negedge with the DUT idle.
   task automatic txn(input bit wr, input logic [1:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] bus,
                      input int aw, input int dw_in, input bit err, input string tag);
      bit   bad;
      int   dw;
      exp_t e;
      bad = ref_bad(sz, addr);
      dw  = (err && dw_in == 0) ? 1 : dw_in;
      e.err   = bad || err;
      e.rdata = (bad || err || wr) ? 32'h0 : ref_read(sz, addr, bus);
      e.tag   = tag;
      sb.push_back(e);

      chk({tag, ":cmd_ready"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_size = sz; cmd_addr = addr; cmd_wdata = wd;
      HREADY = 1'b1; HRESP = 1'b0;
      @(posedge HCLK); @(negedge HCLK);
      // Junk on the command port must be ignored while busy.
      cmd_valid = 1'($urandom_range(0, 1)); cmd_write = 1'($urandom);
      cmd_size = 2'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;

      if (bad) begin
         chk({tag, ":bad_no_nonseq"}, 32'(HTRANS), 32'(HTRANS_IDLE));
         chk({tag, ":bad_rsp_latency"}, 32'(rsp_valid), 32'd1);
      end else begin
         for (int i = 0; i <= aw; i++) begin
            chk({tag, ":HTRANS_addr"}, 32'(HTRANS), 32'(HTRANS_NONSEQ));
            chk({tag, ":HADDR"}, HADDR, addr);
            chk({tag, ":HWRITE"}, 32'(HWRITE), 32'(wr));
            chk({tag, ":HSIZE"}, 32'(HSIZE), 32'({1'b0, sz}));
            HREADY = (i == aw);
            HRDATA = $urandom;
            @(posedge HCLK); @(negedge HCLK);
         end
         for (int i = 0; i <= dw; i++) begin
            chk({tag, ":HTRANS_data"}, 32'(HTRANS), 32'(HTRANS_IDLE));
            chk({tag, ":HWDATA"}, HWDATA, wr ? ref_wlanes(sz, wd) : 32'h0);
            chk({tag, ":rsp_early"}, 32'(rsp_valid), 32'd0);
            HREADY = (i == dw);
            HRESP  = err && (i >= dw - 1);
            HRDATA = (i == dw) ? bus : $urandom;
            @(posedge HCLK); @(negedge HCLK);
         end
         chk({tag, ":rsp_latency"}, 32'(rsp_valid), 32'd1);
         chk({tag, ":HWDATA_resp"}, HWDATA, 32'h0);
         chk({tag, ":HTRANS_resp"}, 32'(HTRANS), 32'(HTRANS_IDLE));
      end
      cmd_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
      @(posedge HCLK); @(negedge HCLK);
      chk({tag, ":rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'b00;
      cmd_addr = 32'h0; cmd_wdata = 32'h0; HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
      #1;
      chk("rst:HTRANS", 32'(HTRANS), 32'd0);
      chk("rst:HADDR", HADDR, 32'h0);
      chk("rst:HWRITE", 32'(HWRITE), 32'd0);
      chk("rst:HSIZE", 32'(HSIZE), 32'd0);
      chk("rst:HWDATA", HWDATA, 32'h0);
      chk("rst:rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst:rsp_rdata", rsp_rdata, 32'h0);
      chk("rst:rsp_err", 32'(rsp_err), 32'd0);
      chk("rst:HBURST", 32'(HBURST), 32'(HBURST_SINGLE));
      chk("rst:HPROT", 32'(HPROT), 32'h3);
      chk("rst:HMASTLOCK", 32'(HMASTLOCK), 32'd0);
      repeat (3) @(negedge HCLK);
      HRESETn = 1'b1;
      @(negedge HCLK);

      txn(1'b0, SZ_WORD, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0, "word_read");
      txn(1'b0, SZ_BYTE, 32'h0000_0013, 32'h0, 32'hA1B2_C3D4, 0, 0, 1'b0, "byte_read");
      txn(1'b0, SZ_HALF, 32'h0000_0012, 32'h0, 32'hA1B2_C3D4, 0, 0, 1'b0, "half_read");
      txn(1'b1, SZ_BYTE, 32'h0000_0001, 32'h0000_005A, 32'h0, 0, 2, 1'b0, "byte_write_wait");
      txn(1'b0, SZ_WORD, 32'h0000_0020, 32'h0, 32'h1234_5678, 0, 1, 1'b1, "err_2cyc");
      txn(1'b0, SZ_WORD, 32'h0000_0002, 32'h0, 32'h0, 0, 0, 1'b0, "misaligned_word");
      txn(1'b1, 2'b11, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 0, 0, 1'b0, "reserved_size");

      // Reset while in DATA on a write: bus must drop to idle immediately.
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_size = SZ_HALF;
      cmd_addr = 32'h0000_0040; cmd_wdata = 32'h0000_BEEF;
      @(posedge HCLK); @(negedge HCLK);
      cmd_valid = 1'b0;
      @(posedge HCLK); @(negedge HCLK);
      HREADY = 1'b0;
      chk("rstmid:HWDATA_before", HWDATA, 32'hBEEF_BEEF);
      #1 HRESETn = 1'b0;
      #1;
      chk("rstmid:HTRANS", 32'(HTRANS), 32'd0);
      chk("rstmid:rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rstmid:HWDATA", HWDATA, 32'h0);
      HREADY = 1'b1;
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
      @(negedge HCLK);
      chk("rstmid:cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rstmid:no_rsp", 32'(rsp_valid), 32'd0);

      for (int n = 0; n < 200; n++) begin
         logic [1:0]  sz;
         logic [31:0] a;
         sz = 2'($urandom_range(0, 3));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'h1 << sz) - 32'h1);
         txn(1'($urandom), sz, a, $urandom, $urandom,
             $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 5) == 0, "rand");
      end

      repeat (2) @(negedge HCLK);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 SHALL have parameter: HPROT_VAL, 4'b0011, constant HPROT value (non-cacheable, non-bufferable, privileged, data).
REQ-002 SHALL have port: HCLK  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: HRESETn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: cmd_valid  in  1  command request.
REQ-005 SHALL have port: cmd_ready  out  1  command accept; transfer occurs when cmd_valid&cmd_ready at a rising edge.
REQ-006 SHALL have port: cmd_write  in  1  1=write, 0=read.
REQ-007 SHALL have port: cmd_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port: cmd_addr  in  32  byte address.
REQ-009 SHALL have port: cmd_wdata  in  32  write data, right-aligned.
REQ-010 SHALL have port: rsp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have port: rsp_rdata  out  32  read data, right-aligned, zero-extended; 0 for writes and errors.
REQ-012 SHALL have port: rsp_err  out  1  completion status, valid with rsp_valid.
REQ-013 SHALL have AHB-Lite master ports: HADDR out 32, HTRANS out 2, HWRITE out 1, HSIZE out 3, HBURST out 3, HPROT out 4, HMASTLOCK out 1, HWDATA out 32, HRDATA in 32, HREADY in 1, HRESP in 1.

Function
REQ-014 SHALL implement states IDLE, ADDR, DATA, RESP; only one transfer outstanding; no address/data pipelining.
REQ-015 SHALL assert cmd_ready only in IDLE; on acceptance, register command and go to ADDR, or to RESP if misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11.
REQ-016 SHALL in ADDR drive HTRANS=NONSEQ (10), HADDR=cmd_addr, HWRITE, HSIZE={1'b0,cmd_size}, all held stable until a rising edge with HREADY=1, then go to DATA.
REQ-017 SHALL drive HTRANS=IDLE (00) in every state except ADDR; HBURST=SINGLE (000), HMASTLOCK=0, HPROT=HPROT_VAL always.
REQ-018 SHALL in DATA drive HWDATA for writes: byte replicated to all four lanes, halfword replicated to both halves, word unchanged; HWDATA held until HREADY=1.
REQ-019 SHALL complete DATA at the rising edge with HREADY=1: capture lane-extracted HRDATA (byte lane addr[1:0], halfword lane addr[1]) for reads, capture HRESP into rsp_err, go to RESP.
REQ-020 SHALL treat HRESP=1 with HREADY=0 (first error cycle) as a wait state; only the HREADY=1 cycle ends the transfer.
REQ-021 SHALL in RESP assert rsp_valid for exactly one cycle, then return to IDLE; misaligned/reserved commands produce rsp_err=1 with no bus activity.
REQ-022 SHALL have minimum latency: acceptance edge E0, NONSEQ in cycle after E0, rsp_valid in third cycle after E0 (zero wait states); each HREADY=0 cycle adds one cycle.
REQ-023 SHALL ignore cmd_* inputs outside IDLE; rsp_valid is not back-pressured.
REQ-024 SHALL hold HWDATA at 0 outside DATA and rsp_rdata/rsp_err at last value between pulses.

Reset
REQ-025 SHALL on HRESETn low, asynchronously: state IDLE, HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; cmd_ready=1 after release.
REQ-026 SHALL on reset mid-transfer (any state) abandon the transfer without issuing rsp_valid.

Structure
REQ-027 SHALL place HTRANS codes, HSIZE codes, HBURST_SINGLE and the state encoding in shared package ahb_pkg.
REQ-028 SHALL put read-lane extraction and write-lane replication in one combinational sub-module, ahb_data_align.

Verification
REQ-029 SHALL check word read 0x0000_0010, HRDATA=0xDEADBEEF, zero waits -> NONSEQ 1 cycle, rsp_valid 3 cycles after accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-030 SHALL check byte read addr 0x13, HRDATA=0xA1B2C3D4 -> HSIZE=000, rsp_rdata=0x000000A1; halfword read addr 0x12 -> 0x0000A1B2.
REQ-031 SHALL check byte write addr 0x01, cmd_wdata=0x0000005A, two HREADY=0 cycles in DATA -> HWDATA=0x5A5A5A5A held 3 cycles, rsp_valid 5 cycles after accept.
REQ-032 SHALL check two-cycle error (HRESP=1/HREADY=0 then HRESP=1/HREADY=1) -> rsp_err=1, rsp_rdata=0, HTRANS=00 throughout DATA.
REQ-033 SHALL check word command at addr 0x02 -> no NONSEQ issued, rsp_valid with rsp_err=1 one cycle after accept.
REQ-034 SHALL check HRESETn asserted while in DATA -> HTRANS=00 and rsp_valid=0 immediately, cmd_ready=1 after release.
